mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and
// the latched bus request that is replayed on the bus until mem_ready.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        INSTR_WAIT = 2'd2
    } arbState_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } busReq_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts bus wait cycles; expired flags that the access has waited LIMIT-1
// cycles without completion and saturates there until cleared.
module mem_wait_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage,
// freezing the pipeline while a multi-cycle bus access is outstanding.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_mem,
    output logic              bus_err
);

    arbState_t state, nextState;
    busReq_t   busReq, nextBusReq;
    logic      discard, nextDiscard;
    logic      inWait, timerExpired, timeout;
    logic      dataDone, instrDone;

    assign inWait    = (state == DATA_WAIT) || (state == INSTR_WAIT);
    assign timeout   = inWait && !mem_ready && timerExpired;
    assign dataDone  = (state == DATA_WAIT) && mem_ready;
    assign instrDone = (state == INSTR_WAIT) && mem_ready;

    mem_wait_timer #(.LIMIT(TIMEOUT_CYC)) waitTimer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!inWait),
        .enable  (inWait && !mem_ready),
        .expired (timerExpired)
    );

    // After a timeout no new access starts: the fault is fatal until reset.
    always_comb begin
        nextState   = state;
        nextBusReq  = busReq;
        nextDiscard = discard;
        case (state)
            IDLE: begin
                if (!bus_err) begin
                    if (dm_req) begin
                        nextBusReq.we    = dm_we;
                        nextBusReq.addr  = ARB_ADDR_W'(dm_addr);
                        nextBusReq.wdata = ARB_DATA_W'(dm_wdata);
                        nextState        = DATA_WAIT;
                    end else if (if_req) begin
                        nextBusReq.we    = 1'b0;
                        nextBusReq.addr  = ARB_ADDR_W'(if_addr);
                        nextBusReq.wdata = '0;
                        nextState        = INSTR_WAIT;
                    end
                end
            end
            DATA_WAIT: begin
                if (mem_ready || timerExpired) begin
                    nextState = IDLE;
                end
            end
            INSTR_WAIT: begin
                if (mem_ready || timerExpired) begin
                    nextState   = IDLE;
                    nextDiscard = 1'b0;
                end else if (if_kill) begin
                    nextDiscard = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busReq   <= '0;
            discard  <= 1'b0;
            bus_err  <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state    <= nextState;
            busReq   <= nextBusReq;
            discard  <= nextDiscard;
            dm_valid <= dataDone;
            if_valid <= instrDone && !discard && !if_kill;
            if (timeout) begin
                bus_err <= 1'b1;
            end
            if (dataDone) begin
                dm_rdata <= busReq.we ? '0 : mem_rdata;
            end
            if (instrDone && !discard && !if_kill) begin
                if_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = inWait;
    assign mem_we    = inWait && busReq.we;
    assign mem_addr  = inWait ? ADDR_W'(busReq.addr) : '0;
    assign mem_wdata = inWait ? DATA_W'(busReq.wdata) : '0;

    assign stall_mem = (dm_req && !dm_valid) || (if_req && !if_valid && !if_kill);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, mem_req, mem_we, stall_mem, bus_err;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_mem (stall_mem),
        .bus_err   (bus_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic ifKill,
                                 input logic dmReq, input logic dmWe, input logic [31:0] dmAddr,
                                 input logic [31:0] dmWdata, input logic memReady, input logic [31:0] memRdata);
        if_req    = ifReq;
        if_addr   = ifAddr;
        if_kill   = ifKill;
        dm_req    = dmReq;
        dm_we     = dmWe;
        dm_addr   = dmAddr;
        dm_wdata  = dmWdata;
        mem_ready = memReady;
        mem_rdata = memRdata;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_if_valid", if_valid, 0);
        checkOutput("rst_dm_valid", dm_valid, 0);
        checkOutput("rst_bus_err", bus_err, 0);
        checkOutput("rst_stall", stall_mem, 0);
        reset = 1'b0;
        tick();

        // 1: plain fetch, mem_ready on the second bus cycle
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t1_mem_req", mem_req, 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h100);
        checkOutput("t1_mem_we", mem_we, 0);
        checkOutput("t1_stall_a", stall_mem, 1);
        tick();
        checkOutput("t1_stall_b", stall_mem, 1);
        checkOutput("t1_if_valid_early", if_valid, 0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h00500093);
        tick();
        checkOutput("t1_if_valid", if_valid, 1);
        checkOutput("t1_if_rdata", if_rdata, 32'h00500093);
        checkOutput("t1_stall_rel", stall_mem, 0);
        checkOutput("t1_mem_req_idle", mem_req, 0);
        applyStimulus(0, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t1_if_valid_pulse", if_valid, 0);

        // 2: simultaneous load and fetch; data goes first
        applyStimulus(1, 32'h300, 0, 1, 0, 32'h2000, 0, 0, 0);
        tick();
        checkOutput("t2_mem_addr", mem_addr, 32'h2000);
        checkOutput("t2_mem_we", mem_we, 0);
        checkOutput("t2_mem_req", mem_req, 1);
        applyStimulus(1, 32'h300, 0, 1, 0, 32'h2000, 0, 1, 32'h11223344);
        tick();
        checkOutput("t2_dm_valid", dm_valid, 1);
        checkOutput("t2_dm_rdata", dm_rdata, 32'h11223344);
        checkOutput("t2_if_valid", if_valid, 0);
        checkOutput("t2_stall_fetch", stall_mem, 1);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t2_fetch_addr", mem_addr, 32'h300);
        checkOutput("t2_fetch_req", mem_req, 1);
        checkOutput("t2_dm_valid_pulse", dm_valid, 0);
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'hAABBCCDD);
        tick();
        checkOutput("t2_if_valid", if_valid, 1);
        checkOutput("t2_if_rdata", if_rdata, 32'hAABBCCDD);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // 3: store; bus fields must hold even if the inputs move
        applyStimulus(0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 0);
        tick();
        checkOutput("t3_mem_we", mem_we, 1);
        checkOutput("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("t3_mem_addr", mem_addr, 32'h40);
        applyStimulus(0, 0, 0, 1, 0, 32'h99, 32'h0, 0, 0);
        tick();
        checkOutput("t3_wdata_hold", mem_wdata, 32'hDEADBEEF);
        checkOutput("t3_addr_hold", mem_addr, 32'h40);
        checkOutput("t3_we_hold", mem_we, 1);
        applyStimulus(0, 0, 0, 1, 0, 32'h99, 32'h0, 1, 32'h12345678);
        tick();
        checkOutput("t3_dm_valid", dm_valid, 1);
        checkOutput("t3_dm_rdata", dm_rdata, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // 4: redirect while the fetch is in flight
        applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_mem_addr", mem_addr, 32'h104);
        applyStimulus(1, 32'h104, 1, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_kill_req_held", mem_req, 1);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h00000BAD);
        tick();
        checkOutput("t4_no_if_valid", if_valid, 0);
        checkOutput("t4_mem_req_idle", mem_req, 0);
        checkOutput("t4_stall", stall_mem, 1);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t4_new_addr", mem_addr, 32'h200);
        checkOutput("t4_new_req", mem_req, 1);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h00000013);
        tick();
        checkOutput("t4_if_valid", if_valid, 1);
        checkOutput("t4_if_rdata", if_rdata, 32'h00000013);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // 5: bus never answers; 8 wait cycles then abort
        applyStimulus(0, 0, 0, 1, 0, 32'h500, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checkOutput($sformatf("t5_req_cyc%0d", i), mem_req, 1);
        end
        tick();
        checkOutput("t5_req_dropped", mem_req, 0);
        checkOutput("t5_bus_err", bus_err, 1);
        checkOutput("t5_no_dm_valid", dm_valid, 0);
        checkOutput("t5_stall", stall_mem, 1);
        tick();
        tick();
        tick();
        checkOutput("t5_req_stays_low", mem_req, 0);
        checkOutput("t5_bus_err_sticky", bus_err, 1);

        // 6: reset in the middle of a data access
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        checkOutput("t6_err_cleared", bus_err, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 32'h600, 0, 0, 0);
        tick();
        checkOutput("t6_mem_req", mem_req, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_req_after_rst", mem_req, 0);
        checkOutput("t6_no_dm_valid", dm_valid, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        tick();
        checkOutput("t6_late_ready_dm", dm_valid, 0);
        checkOutput("t6_late_ready_if", if_valid, 0);
        checkOutput("t6_late_ready_req", mem_req, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("t6_idle_dm_valid", dm_valid, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
